// File: rtl/vga_arb_pkg.sv
// Shared types and default constants for the VGA framebuffer arbiter.
package vga_arb_pkg;

    localparam int ARB_H_ACTIVE = 640;
    localparam int ARB_AW       = 19;
    localparam int ARB_DW       = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PIX_ISSUE = 2'd1,
        PIX_WAIT  = 2'd2,
        WR_ISSUE  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] data;
    } wr_entry_t;

    // Linear framebuffer address of an active-area pixel, truncated to the RAM width.
    function automatic logic [ARB_AW-1:0] lin_addr(input logic [9:0] v, input logic [9:0] h,
                                                   input int unsigned h_active);
        return ARB_AW'(32'(v) * h_active + 32'(h));
    endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Synchronous FIFO holding CPU {addr,data} write entries in acceptance order.
module fb_write_fifo
    import vga_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  wr_entry_t              i_push_entry,
    input  logic                   i_pop,
    output wr_entry_t              o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PW = $clog2(DEPTH);

    wr_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == (PW+1)'(DEPTH));
    assign o_empty   = (r_level == {(PW+1){1'b0}});
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Entry storage; validity is carried by the pointers and level alone.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_level  <= {(PW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (PW+1)'(1);
                2'b01:   r_level <= r_level - (PW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: fixed-latency pixel reads win, buffered CPU writes fill idle slots.
// Define VGA_ARB_BLANK_ONLY_EN to restrict FIFO draining to blanking intervals.
module vga_fb_arbiter
    import vga_arb_pkg::*;
#(
    parameter int H_ACTIVE   = ARB_H_ACTIVE,
    parameter int AW         = ARB_AW,
    parameter int DW         = ARB_DW,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_pix_stb,
    input  logic                        i_h_ena,
    input  logic                        i_v_ena,
    input  logic [9:0]                  i_h_pos,
    input  logic [9:0]                  i_v_pos,
    input  logic                        i_wr_valid,
    output logic                        o_wr_ready,
    input  logic [AW-1:0]               i_wr_addr,
    input  logic [DW-1:0]               i_wr_data,
    output logic [AW-1:0]               o_mem_addr,
    output logic                        o_mem_we,
    output logic [DW-1:0]               o_mem_wdata,
    input  logic [DW-1:0]               i_mem_rdata,
    output logic [DW-1:0]               o_pix_data,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

    arb_state_t    r_state;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_pix_data;
    logic          r_s1_vld;
    logic          r_s1_en;
    logic          r_s2_vld;
    logic          r_s2_en;

    wr_entry_t     w_head;
    wr_entry_t     w_push_entry;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_pix_go;
    logic          w_wr_perm;
    logic [AW-1:0] w_pix_addr;

    assign w_pix_go     = i_pix_stb & i_h_ena & i_v_ena;
    assign w_pix_addr   = lin_addr(i_v_pos, i_h_pos, H_ACTIVE);
    assign w_push       = i_wr_valid & ~w_full;
    assign w_push_entry = '{addr: i_wr_addr, data: i_wr_data};
    // The cycle after a read issue is reserved so the read data returns on a quiet port.
    assign w_pop        = ~w_pix_go & (r_state != PIX_ISSUE) & ~w_empty & w_wr_perm;

`ifdef VGA_ARB_BLANK_ONLY_EN
    logic r_blank;

    // Registered blanking flag gates FIFO draining for tear-free updates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blank <= 1'b0;
        end else begin
            r_blank <= ~(i_h_ena & i_v_ena);
        end
    end

    assign w_wr_perm = r_blank;
`else
    assign w_wr_perm = 1'b1;
`endif

    fb_write_fifo #(
        .DEPTH        (FIFO_DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_level      (o_fifo_level)
    );

    // Memory port arbitration: pixel read first, then a FIFO write, else idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_mem_addr  <= {AW{1'b0}};
            r_mem_we    <= 1'b0;
            r_mem_wdata <= {DW{1'b0}};
        end else if (w_pix_go) begin
            r_state     <= PIX_ISSUE;
            r_mem_addr  <= w_pix_addr;
            r_mem_we    <= 1'b0;
        end else if (r_state == PIX_ISSUE) begin
            r_state     <= PIX_WAIT;
            r_mem_we    <= 1'b0;
        end else if (w_pop) begin
            r_state     <= WR_ISSUE;
            r_mem_addr  <= w_head.addr;
            r_mem_wdata <= w_head.data;
            r_mem_we    <= 1'b1;
        end else begin
            r_state     <= IDLE;
            r_mem_we    <= 1'b0;
        end
    end

    // Strobe pipeline: read data is sampled two cycles after the strobe, blanked strobes yield 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_en    <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s2_en    <= 1'b0;
            r_pix_data <= {DW{1'b0}};
        end else begin
            r_s1_vld <= i_pix_stb;
            r_s1_en  <= i_h_ena & i_v_ena;
            r_s2_vld <= r_s1_vld;
            r_s2_en  <= r_s1_en;
            if (r_s2_vld) begin
                r_pix_data <= r_s2_en ? i_mem_rdata : {DW{1'b0}};
            end
        end
    end

    assign o_wr_ready  = ~w_full;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = r_mem_we;
    assign o_mem_wdata = r_mem_wdata;
    assign o_pix_data  = r_pix_data;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized self-checking bench for vga_fb_arbiter against a cycle-level reference of the arbitration rules.
module tb_vga_fb_arbiter;

    localparam int H_ACT = 640;
    localparam int MEMSZ = 1 << 19;

    typedef struct {
        int         due;
        logic [7:0] val;
    } pix_t;

    typedef struct {
        logic [18:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        pix_stb;
    logic        h_ena;
    logic        v_ena;
    logic [9:0]  h_pos;
    logic [9:0]  v_pos;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  pix_data;
    logic [3:0]  fifo_level;

    vga_fb_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pix_stb    (pix_stb),
        .i_h_ena      (h_ena),
        .i_v_ena      (v_ena),
        .i_h_pos      (h_pos),
        .i_v_pos      (v_pos),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_pix_data   (pix_data),
        .o_fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        if (a == 1285) return 8'hA5;
        return 8'(a * 37 + 11);
    endfunction

    // Framebuffer RAM seen by the DUT: synchronous read, one cycle latency.
    logic [7:0] dut_ram [MEMSZ];
    bit         dut_wr  [MEMSZ];
    always @(posedge clk) begin
        if (mem_we) begin
            dut_ram[mem_addr] <= mem_wdata;
            dut_wr[mem_addr]  <= 1'b1;
        end
        mem_rdata <= dut_wr[mem_addr] ? dut_ram[mem_addr] : init_val(int'(mem_addr));
    end

    // Reference state
    logic [7:0]  ref_mem [MEMSZ];
    bit          ref_wr  [MEMSZ];
    wr_t         q[$];
    pix_t        pend[$];
    logic [7:0]  exp_pix;
    logic        nx_we, nx_rd, go_prev, blank_prev;
    logic [18:0] nx_addr;
    logic [7:0]  nx_data, nx_old;
    bit          nx_old_wr;
    int          cyc, n_vec, n_err;

    function automatic logic [7:0] ref_rd(input int a);
        return ref_wr[a] ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        q.delete();
        pend.delete();
        exp_pix = 8'd0; nx_we = 1'b0; nx_rd = 1'b0; go_prev = 1'b0; blank_prev = 1'b0;
    endtask

    // One clock cycle: check outputs of this cycle, apply inputs, advance the reference.
    task automatic step(input logic stb, input logic he, input logic ve, input logic [9:0] hp,
                        input logic [9:0] vp, input logic wv, input logic [18:0] wa,
                        input logic [7:0] wd, output logic acc);
        int   sz, a;
        logic go, perm, wr;
        while (pend.size() > 0 && pend[0].due == cyc) begin
            exp_pix = pend[0].val;
            pend.delete(0);
        end
        chk("mem_we", 32'(mem_we), 32'(nx_we));
        if (nx_we) begin
            chk("wr_addr", 32'(mem_addr), 32'(nx_addr));
            chk("wr_data", 32'(mem_wdata), 32'(nx_data));
        end
        if (nx_rd) chk("rd_addr", 32'(mem_addr), 32'(nx_addr));
        chk("level", 32'(fifo_level), 32'(q.size()));
        chk("wr_ready", 32'(wr_ready), 32'(q.size() < 8));
        chk("pix_data", 32'(pix_data), 32'(exp_pix));

        pix_stb = stb; h_ena = he; v_ena = ve; h_pos = hp; v_pos = vp;
        wr_valid = wv; wr_addr = wa; wr_data = wd;

        go = stb && he && ve;
        sz = q.size();
`ifdef VGA_ARB_BLANK_ONLY_EN
        perm = blank_prev;
        blank_prev = !(he && ve);
`else
        perm = 1'b1;
`endif
        wr = !go && !go_prev && sz > 0 && perm;
        nx_we = 1'b0;
        nx_rd = 1'b0;
        if (go) begin
            a = (int'(vp) * H_ACT + int'(hp)) % MEMSZ;
            nx_rd = 1'b1;
            nx_addr = 19'(a);
            pend.push_back('{cyc + 3, ref_rd(a)});
        end else if (stb) begin
            pend.push_back('{cyc + 3, 8'd0});
        end
        if (wr) begin
            nx_we = 1'b1;
            nx_addr = q[0].a;
            nx_data = q[0].d;
            nx_old = ref_mem[q[0].a];
            nx_old_wr = ref_wr[q[0].a];
            ref_mem[q[0].a] = q[0].d;
            ref_wr[q[0].a] = 1'b1;
            q.delete(0);
        end
        acc = wv && sz < 8;
        if (acc) q.push_back('{wa, wd});
        go_prev = go;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 19'd0, 8'd0, acc);
    endtask

    logic        acc, stb, pending;
    logic [18:0] pa;
    logic [7:0]  pd;
    int          since, k;
    bit          hit;

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        model_clear();
        rst_n = 1'b0; pix_stb = 1'b0; h_ena = 1'b0; v_ena = 1'b0; h_pos = 10'd0; v_pos = 10'd0;
        wr_valid = 1'b0; wr_addr = 19'd0; wr_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_pix", 32'(pix_data), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Pixel at (5,2) -> address 1285 holding 0xA5, then a blanked strobe.
        step(1'b1, 1'b1, 1'b1, 10'd5, 10'd2, 1'b0, 19'd0, 8'd0, acc);
        idle(4);
        step(1'b1, 1'b0, 1'b1, 10'd5, 10'd2, 1'b0, 19'd0, 8'd0, acc);
        idle(4);

        // Three queued writes under strobes every two cycles.
        for (int i = 0; i < 12; i++)
            step((i % 2) == 0, 1'b1, 1'b1, 10'(i), 10'd1, i < 3, 19'(10 + i), 8'(1 + i), acc);
        idle(12);

        // Write 100=0x3C; read before the drain returns old data, after it the new value.
        step(1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 19'd100, 8'h3C, acc);
        step(1'b1, 1'b1, 1'b1, 10'd100, 10'd0, 1'b0, 19'd0, 8'd0, acc);
        idle(8);
        step(1'b1, 1'b1, 1'b1, 10'd100, 10'd0, 1'b0, 19'd0, 8'd0, acc);
        idle(5);

        // Fill the FIFO during active strobes, then drain in blanking.
        k = 0;
        for (int i = 0; i < 20; i++) begin
            step((i % 2) == 0, 1'b1, 1'b1, 10'(i), 10'd3, k < 12, 19'(200 + k), 8'(k), acc);
            if (acc) k++;
        end
        for (int i = 0; i < 24; i++) begin
            step((i % 2) == 0, 1'b0, 1'b1, 10'(i), 10'd3, k < 12, 19'(200 + k), 8'(k), acc);
            if (acc) k++;
        end
        idle(10);

        // Randomized traffic with a CPU that holds its request until accepted.
        since = 2; pending = 1'b0; pa = 19'd0; pd = 8'd0;
        for (int i = 0; i < 3000; i++) begin
            stb = (since >= 2) && ($urandom_range(1, 0) == 1);
            if (!pending && $urandom_range(9, 0) < 4) begin
                pending = 1'b1;
                pa = 19'($urandom_range(2047, 0));
                pd = 8'($urandom);
            end
            step(stb, $urandom_range(9, 0) < 8, $urandom_range(9, 0) < 9,
                 10'($urandom_range(15, 0)), 10'($urandom_range(3, 0)), pending, pa, pd, acc);
            if (acc) pending = 1'b0;
            since = stb ? 1 : since + 1;
        end
        idle(20);

        // Reset in the middle of a write with four entries still queued.
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (nx_we && q.size() == 4) begin
                hit = 1'b1;
            end else begin
                step(i < 10 && (i % 2) == 0, i < 10, 1'b1, 10'(i), 10'd0, i < 5,
                     19'(300 + i), 8'(i + 7), acc);
            end
        end
        chk("rst_setup", 32'(hit), 32'd1);
        if (hit) begin
            chk("pre_rst_we", 32'(mem_we), 32'd1);
            chk("pre_rst_level", 32'(fifo_level), 32'd4);
            rst_n = 1'b0;
            pix_stb = 1'b0; h_ena = 1'b0; v_ena = 1'b0; wr_valid = 1'b0;
            #1;
            chk("mid_rst_we", 32'(mem_we), 32'd0);
            chk("mid_rst_level", 32'(fifo_level), 32'd0);
            chk("mid_rst_ready", 32'(wr_ready), 32'd1);
            chk("mid_rst_pix", 32'(pix_data), 32'd0);
            if (nx_we) begin
                ref_mem[nx_addr] = nx_old;
                ref_wr[nx_addr] = nx_old_wr;
            end
            model_clear();
            repeat (2) @(negedge clk);
            cyc += 2;
            rst_n = 1'b1;
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 6; i++)
            step((i % 2) == 0, 1'b1, 1'b1, 10'(300 + i), 10'd0, 1'b0, 19'd0, 8'd0, acc);
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between the VGA pixel fetch path and CPU write traffic.
- Sits between the horizontal/vertical sync counters (pixel strobe, enables, positions) and the framebuffer memory.
- Pixel fetch has absolute priority and a fixed latency. CPU writes are buffered in a FIFO and drained into free memory slots.

Parameters:
- H_ACTIVE, 640, active pixels per line; used for the linear address.
- AW, 19, framebuffer address width.
- DW, 8, pixel/data width.
- FIFO_DEPTH, 8, CPU write FIFO entries (power of two, ≥2).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- PIX_STB  in  1  one-cycle pixel strobe; spacing ≥2 CLK cycles
- H_ENA  in  1  horizontal RGB enable from the horizontal sync counter
- V_ENA  in  1  vertical RGB enable from the vertical sync counter
- H_POS  in  10  active-area column
- V_POS  in  10  active-area row
- WR_VALID  in  1  CPU write request
- WR_READY  out  1  FIFO can accept a write
- WR_ADDR  in  AW  CPU write address
- WR_DATA  in  DW  CPU write data
- MEM_ADDR  out  AW  RAM address (registered)
- MEM_WE  out  1  RAM write enable (registered)
- MEM_WDATA  out  DW  RAM write data (registered)
- MEM_RDATA  in  DW  RAM read data; valid 1 cycle after address
- PIX_DATA  out  DW  pixel to DAC; 0 during blanking
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: all outputs 0 except WR_READY=1. FIFO empties, state goes to IDLE, pipeline valid bits clear. Reset asserted mid-write aborts the write: MEM_WE=0 immediately, and the queued entries are lost.
- Pixel request: at a cycle t where PIX_STB=1, latch pix_req and the enable bit en = H_ENA&V_ENA. The address is V_POS*H_ACTIVE+H_POS, truncated to AW bits.
- Memory read:
  - If en=1, the read is issued at t+1 (MEM_ADDR set, MEM_WE=0).
  - MEM_RDATA is sampled at t+2.
  - PIX_DATA updates at t+3.
- Blanking: if en=0, no memory access is made and PIX_DATA=0 at t+3.
- Fixed latency is 3 CLK from strobe to PIX_DATA. The sync path delays HSYNC/VSYNC to match.
- FSM states: IDLE, PIX_ISSUE, PIX_WAIT, WR_ISSUE.
- Priority applies from every state:
  - pix_req with en=1 → PIX_ISSUE next.
  - Otherwise, FIFO non-empty and write permitted → WR_ISSUE.
  - Otherwise → IDLE.
- PIX_ISSUE always goes to PIX_WAIT, unless a new strobe makes PIX_ISSUE next.
- WR_ISSUE drives the FIFO head for one cycle (MEM_WE=1) and pops it.
- A write never occupies a cycle that a pixel read needs. Pixel reads are never delayed or dropped.
- CPU handshake:
  - A write is accepted on WR_VALID&WR_READY.
  - WR_READY = !full. When full, WR_VALID is ignored and the entry is not dropped; the CPU holds it.
  - Push and pop in the same cycle leave FIFO_LEVEL unchanged.
  - A push into an empty FIFO can issue no earlier than the next cycle.
- FIFO order: writes reach memory in acceptance order. Pointers wrap modulo FIFO_DEPTH.
- Read/write same address: a pixel read at the same address as a pending FIFO write returns the old memory contents. No forwarding is done.

Optional Feature:
- VGA_ARB_BLANK_ONLY_EN
- Defined: "write permitted" = !(H_ENA&V_ENA), registered. FIFO drains only during blanking, giving tear-free updates. During active video WR_READY still reflects the FIFO, so the FIFO may fill.
- Undefined: write permitted in any cycle not claimed by a pixel read.

Decomposition:
- Package vga_arb_pkg holds:
  - the state enum typedef (IDLE, PIX_ISSUE, PIX_WAIT, WR_ISSUE);
  - default AW/DW/H_ACTIVE constants;
  - the write-entry packed struct {addr, data}.
- One sub-module, fb_write_fifo: synchronous FIFO with push/pop/full/empty/level ports and the same CLK/RST.

Test Plan:
- Reset, then H_ENA=V_ENA=1 at H_POS=5, V_POS=2, PIX_STB at t, RAM[1285]=0xA5 → MEM_ADDR=1285 at t+1 and PIX_DATA=0xA5 at t+3.
- PIX_STB with H_ENA=0 → no MEM access and PIX_DATA=0 at t+3.
- Queue 3 writes (addr 10/11/12, data 1/2/3) while PIX_STB every 2 cycles in active area → writes land only in non-pixel cycles, in order. Every pixel still arrives at fixed 3-cycle latency; FIFO_LEVEL returns to 0.
- Hold WR_VALID during continuous strobes (spacing 2, feature defined, active area) → FIFO_LEVEL reaches 8, WR_READY=0, no MEM_WE until H_ENA falls, then 8 consecutive writes.
- Write addr 100=0x3C, then pixel read at 100 after the drain → PIX_DATA=0x3C; pixel read before the drain → old value.
- Assert RST with FIFO_LEVEL=4 mid-WR_ISSUE → MEM_WE=0 immediately, FIFO_LEVEL=0, WR_READY=1, PIX_DATA=0.
